nodf_seq_loop_monitor: RTL and testbench
========================================

# nodf_seq_loop_monitor

Synthesizable, non-intrusive hardware monitor for an HLS-generated, non-dataflow top-level kernel. It passively samples the kernel's block-level handshake (ap_start/ap_ready/ap_done/ap_continue) and its one-hot FSM state register. It exposes saturating transaction, latency and loop-iteration statistics for readout. It sits beside the kernel with no feedback into it, and freezes its statistics when the run signals `finish`.

## Interface
- `STATE_W`, 302: width of the one-hot FSM state vectors.
- `CNT_W`, 32: width of every counter/latency output.

Reset: one clock; reset is asynchronous and active-low.

Ports:
- `clock`  in  1  sampling clock (kernel clock).
- `reset`  in  1  asynchronous, active-low; clears all state.
- `finish`  in  1  end-of-run; sticky freeze of all statistics.
- `ap_start`, `ap_ready`, `ap_done`, `ap_continue`  in  1 each  kernel handshake.
- `cur_state`  in  STATE_W  kernel FSM register (one-hot).
- `pre_loop_state0`, `post_loop_state0`, `quit_loop_state0`, `iter_start_state`, `iter_end_state0`  in  STATE_W  one-hot reference states.
- `pre_states_valid`, `post_states_valid`, `quit_states_valid`, `iter_end_states_valid`  in  1  qualify the matching reference state.
- `one_state_loop`  in  1  loop body is a single state (start == end).
- `one_state_block`  in  1  disables loop tracking.
- `frozen`  out  1  finish has been seen.
- `mod_busy`  out  1  transaction in flight.
- `mod_txn_cnt`, `mod_ready_cnt`, `mod_last_lat`, `mod_max_lat`  out  CNT_W each.
- `loop_active`  out  1.
- `loop_iter_cnt`, `loop_total_iters`, `loop_run_cnt`, `loop_last_trip`, `loop_last_iter_lat`  out  CNT_W each.

## Operation
- **State match:** `X` means `cur_state == X` with the qualifying valid bit high. `prev_state` is `cur_state` registered each cycle.
- **Module handshake**
  - Start accepted: `ap_start` while `!mod_busy`. Sets busy; the latency counter is 1 in that cycle.
  - While busy, the latency counter increments each cycle.
  - Completion: `ap_done & ap_continue` while busy. Increments `mod_txn_cnt`, sets `mod_last_lat` to the counter including the done cycle, and updates `mod_max_lat = max`.
  - Start and done in the same cycle: busy stays 1 and the latency counter restarts at 1.
  - `ap_done` while idle is ignored.
  - Every cycle with `ap_ready=1` increments `mod_ready_cnt`, independent of start.
- **Loop tracking** (skipped entirely while `one_state_block=1`). Evaluation order per cycle: exit, then iteration complete, then entry.
  - Entry: `!loop_active`, `prev_state == pre_loop_state0`, `cur == iter_start_state` → `loop_active=1`, `loop_iter_cnt=0`, iteration latency = 1.
  - Iteration complete: active, `prev == iter_end_state0`, `cur == iter_start_state` → `loop_iter_cnt++`, `loop_total_iters++`, `loop_last_iter_lat` = iteration latency, iteration latency reset to 1.
  - When `one_state_loop=1`, `iter_end_state0` is treated as `iter_start_state`, so the iteration-complete rule fires every cycle the FSM stays in the start state.
  - Exit: active, `prev == quit_loop_state0`, `cur == post_loop_state0` → `loop_active=0`, `loop_run_cnt++`, `loop_last_trip = loop_iter_cnt`.
  - Any other active cycle: iteration latency++.
- **Counters:** all counters saturate at all-ones and never wrap.
- **Freeze:** `finish=1` sampled high sets sticky `frozen`. From the next edge, every output holds until reset.

## Timing
- All outputs are registered, with one-cycle latency from the triggering sampled inputs.
- Reset values: every output is 0, `prev_state` is 0.
- Reset asserted mid-transaction or mid-loop clears everything immediately. No partial statistics are kept.
- `finish` in the same cycle as a completion: that completion is still recorded, then the block freezes.

## Structure
- Package `nodf_mon_pkg`: `CNT_W` default and a function `sat_inc(cnt)` for saturating increment.
- One sub-module, `nodf_handshake_mon`, holds the handshake counters. The top holds the loop tracker and the freeze logic.

## Test plan
All scenarios use `STATE_W=302`, `pre = post = bit0`, `quit = iter_start = bit1`, `iter_end = bit301`.
- **Reset:** hold `reset=0` for 5 cycles with random inputs → all outputs 0.
- **Single transaction:** `ap_start` pulse at cycle 0, `ap_done=ap_continue=1` at cycle 9 → `mod_txn_cnt=1`, `mod_last_lat=10`, `mod_max_lat=10`, `mod_busy=0`.
- **Ready-only:** `ap_start=0`, `ap_done=0`, `ap_ready` high for 3 cycles → `mod_ready_cnt=3`, `mod_txn_cnt=0`.
- **Loop run:** FSM bit0 → bit1 → bits2..301 → bit1, repeated 4 times, then bit1 → bit0 → `loop_total_iters=4`, `loop_run_cnt=1`, `loop_last_trip=4`, `loop_last_iter_lat=301`, `loop_active=0`.
- **one_state_block=1, same FSM sequence:** loop outputs stay 0.
- **Freeze:** assert `finish` mid-transaction, then complete it → `frozen=1` and `mod_txn_cnt` unchanged.

Source files
------------

// File: rtl/nodf_seq_loop_monitor_pkg.sv
// Shared types for the non-dataflow kernel monitor: counter width, state
// encodings of the two trackers and the saturating increment helper.
package nodf_mon_pkg;

  localparam int CNT_W       = 32;
  localparam int STATE_W_DEF = 302;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic {
    HS_IDLE = 1'b0,
    HS_BUSY = 1'b1
  } hs_state_e;

  typedef enum logic {
    LOOP_IDLE   = 1'b0,
    LOOP_ACTIVE = 1'b1
  } loop_state_e;

  // Counters stick at all-ones instead of wrapping.
  function automatic cnt_t sat_inc(input cnt_t cnt);
    return (&cnt) ? cnt : cnt + cnt_t'(1);
  endfunction

endpackage

// File: rtl/nodf_seq_loop_monitor_if.sv
// Signal bundle between an HLS kernel (plus its reference-state constants)
// and the passive monitor that observes it.
interface nodf_seq_loop_monitor_if #(
  parameter int STATE_W = nodf_mon_pkg::STATE_W_DEF
);
  import nodf_mon_pkg::*;

  // Kernel block protocol: ap_start is taken only while the monitor is idle;
  // a transaction completes on ap_done & ap_continue while busy; ap_ready is
  // counted every cycle it is high, independent of the transaction state.
  logic               finish;
  logic               ap_start;
  logic               ap_ready;
  logic               ap_done;
  logic               ap_continue;
  logic [STATE_W-1:0] cur_state;
  logic [STATE_W-1:0] pre_loop_state0;
  logic [STATE_W-1:0] post_loop_state0;
  logic [STATE_W-1:0] quit_loop_state0;
  logic [STATE_W-1:0] iter_start_state;
  logic [STATE_W-1:0] iter_end_state0;
  logic               pre_states_valid;
  logic               post_states_valid;
  logic               quit_states_valid;
  logic               iter_end_states_valid;
  logic               one_state_loop;
  logic               one_state_block;

  logic               frozen;
  logic               mod_busy;
  cnt_t               mod_txn_cnt;
  cnt_t               mod_ready_cnt;
  cnt_t               mod_last_lat;
  cnt_t               mod_max_lat;
  logic               loop_active;
  cnt_t               loop_iter_cnt;
  cnt_t               loop_total_iters;
  cnt_t               loop_run_cnt;
  cnt_t               loop_last_trip;
  cnt_t               loop_last_iter_lat;

  modport master (
    output finish, ap_start, ap_ready, ap_done, ap_continue, cur_state,
           pre_loop_state0, post_loop_state0, quit_loop_state0,
           iter_start_state, iter_end_state0, pre_states_valid,
           post_states_valid, quit_states_valid, iter_end_states_valid,
           one_state_loop, one_state_block,
    input  frozen, mod_busy, mod_txn_cnt, mod_ready_cnt, mod_last_lat,
           mod_max_lat, loop_active, loop_iter_cnt, loop_total_iters,
           loop_run_cnt, loop_last_trip, loop_last_iter_lat
  );

  modport slave (
    input  finish, ap_start, ap_ready, ap_done, ap_continue, cur_state,
           pre_loop_state0, post_loop_state0, quit_loop_state0,
           iter_start_state, iter_end_state0, pre_states_valid,
           post_states_valid, quit_states_valid, iter_end_states_valid,
           one_state_loop, one_state_block,
    output frozen, mod_busy, mod_txn_cnt, mod_ready_cnt, mod_last_lat,
           mod_max_lat, loop_active, loop_iter_cnt, loop_total_iters,
           loop_run_cnt, loop_last_trip, loop_last_iter_lat
  );

endinterface

// File: rtl/nodf_seq_loop_monitor_handshake_mon.sv
// Block-level handshake statistics: transaction count, ready count and
// start-to-done latency (last and maximum), all saturating.
module nodf_handshake_mon
  import nodf_mon_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic ap_start_i,
  input  logic ap_ready_i,
  input  logic ap_done_i,
  input  logic ap_continue_i,
  output logic busy_o,
  output cnt_t txn_cnt_o,
  output cnt_t ready_cnt_o,
  output cnt_t last_lat_o,
  output cnt_t max_lat_o
);

  hs_state_e st_q;
  cnt_t      lat_q;
  cnt_t      txn_cnt_q;
  cnt_t      ready_cnt_q;
  cnt_t      last_lat_q;
  cnt_t      max_lat_q;

  logic      done_d;
  cnt_t      done_lat_d;

  assign done_d     = ap_done_i & ap_continue_i;
  // Latency reported on completion includes the done cycle itself.
  assign done_lat_d = sat_inc(lat_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      st_q        <= HS_IDLE;
      lat_q       <= '0;
      txn_cnt_q   <= '0;
      ready_cnt_q <= '0;
      last_lat_q  <= '0;
      max_lat_q   <= '0;
    end else if (en_i) begin
      if (ap_ready_i) ready_cnt_q <= sat_inc(ready_cnt_q);
      case (st_q)
        HS_IDLE: begin
          if (ap_start_i) begin
            st_q  <= HS_BUSY;
            lat_q <= cnt_t'(1);
          end
        end
        HS_BUSY: begin
          if (done_d) begin
            txn_cnt_q  <= sat_inc(txn_cnt_q);
            last_lat_q <= done_lat_d;
            if (done_lat_d > max_lat_q) max_lat_q <= done_lat_d;
            // Back-to-back start keeps the block busy with a fresh count.
            if (ap_start_i) begin
              lat_q <= cnt_t'(1);
            end else begin
              st_q  <= HS_IDLE;
              lat_q <= '0;
            end
          end else begin
            lat_q <= sat_inc(lat_q);
          end
        end
      endcase
    end
  end

  assign busy_o      = (st_q == HS_BUSY);
  assign txn_cnt_o   = txn_cnt_q;
  assign ready_cnt_o = ready_cnt_q;
  assign last_lat_o  = last_lat_q;
  assign max_lat_o   = max_lat_q;

endmodule

// File: rtl/nodf_seq_loop_monitor.sv
// Passive monitor for a non-dataflow HLS kernel: handshake statistics via the
// sub-module, loop tracking from the one-hot FSM register, sticky freeze.
module nodf_seq_loop_monitor
  import nodf_mon_pkg::*;
#(
  parameter int STATE_W = STATE_W_DEF
) (
  input  logic                    clock,
  input  logic                    reset,
  nodf_seq_loop_monitor_if.slave  bus
);

  logic               frozen_q;
  logic [STATE_W-1:0] prev_q;
  loop_state_e        loop_st_q;
  cnt_t               iter_cnt_q;
  cnt_t               total_iters_q;
  cnt_t               run_cnt_q;
  cnt_t               last_trip_q;
  cnt_t               last_iter_lat_q;
  cnt_t               iter_lat_q;

  logic start_cur_d;
  logic end_prev_d;
  logic entry_d;
  logic iter_d;
  logic exit_d;

  assign start_cur_d = (bus.cur_state == bus.iter_start_state);
  // A single-state body ends wherever it starts.
  assign end_prev_d  = bus.one_state_loop ? (prev_q == bus.iter_start_state)
                     : (bus.iter_end_states_valid && (prev_q == bus.iter_end_state0));
  assign entry_d     = bus.pre_states_valid && (prev_q == bus.pre_loop_state0) && start_cur_d;
  assign iter_d      = end_prev_d && start_cur_d;
  assign exit_d      = bus.quit_states_valid && (prev_q == bus.quit_loop_state0) &&
                       bus.post_states_valid && (bus.cur_state == bus.post_loop_state0);

  nodf_handshake_mon u_hs (
    .clk_i         (clock),
    .rst_ni        (reset),
    .en_i          (!frozen_q),
    .ap_start_i    (bus.ap_start),
    .ap_ready_i    (bus.ap_ready),
    .ap_done_i     (bus.ap_done),
    .ap_continue_i (bus.ap_continue),
    .busy_o        (bus.mod_busy),
    .txn_cnt_o     (bus.mod_txn_cnt),
    .ready_cnt_o   (bus.mod_ready_cnt),
    .last_lat_o    (bus.mod_last_lat),
    .max_lat_o     (bus.mod_max_lat)
  );

  // Exit wins over iteration completion, which wins over entry.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      frozen_q        <= 1'b0;
      prev_q          <= '0;
      loop_st_q       <= LOOP_IDLE;
      iter_cnt_q      <= '0;
      total_iters_q   <= '0;
      run_cnt_q       <= '0;
      last_trip_q     <= '0;
      last_iter_lat_q <= '0;
      iter_lat_q      <= '0;
    end else if (!frozen_q) begin
      frozen_q <= bus.finish;
      prev_q   <= bus.cur_state;
      if (!bus.one_state_block) begin
        case (loop_st_q)
          LOOP_IDLE: begin
            if (entry_d) begin
              loop_st_q  <= LOOP_ACTIVE;
              iter_cnt_q <= '0;
              iter_lat_q <= cnt_t'(1);
            end
          end
          LOOP_ACTIVE: begin
            if (exit_d) begin
              loop_st_q   <= LOOP_IDLE;
              run_cnt_q   <= sat_inc(run_cnt_q);
              last_trip_q <= iter_cnt_q;
            end else if (iter_d) begin
              iter_cnt_q      <= sat_inc(iter_cnt_q);
              total_iters_q   <= sat_inc(total_iters_q);
              last_iter_lat_q <= iter_lat_q;
              iter_lat_q      <= cnt_t'(1);
            end else begin
              iter_lat_q <= sat_inc(iter_lat_q);
            end
          end
        endcase
      end
    end
  end

  assign bus.frozen             = frozen_q;
  assign bus.loop_active        = (loop_st_q == LOOP_ACTIVE);
  assign bus.loop_iter_cnt      = iter_cnt_q;
  assign bus.loop_total_iters   = total_iters_q;
  assign bus.loop_run_cnt       = run_cnt_q;
  assign bus.loop_last_trip     = last_trip_q;
  assign bus.loop_last_iter_lat = last_iter_lat_q;

endmodule

// File: tb/tb_nodf_seq_loop_monitor.sv
// Directed and randomized bench for nodf_seq_loop_monitor with a
// transaction/loop-level reference model.
module tb_nodf_seq_loop_monitor;
  import nodf_mon_pkg::*;

  localparam int STATE_W = 302;

  logic clock;
  logic reset;

  nodf_seq_loop_monitor_if #(.STATE_W(STATE_W)) mon_if ();

  nodf_seq_loop_monitor #(.STATE_W(STATE_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (mon_if.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: handshake as start/done cycle stamps, loops as trip/body lengths.
  logic m_frozen;
  logic m_busy;
  int   m_start, m_txn, m_ready, m_last, m_max;
  logic m_active;
  int   m_iter, m_total, m_run, m_trip, m_last_iter;

  function automatic logic [STATE_W-1:0] onehot(input int b);
    logic [STATE_W-1:0] v;
    v    = '0;
    v[b] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_frozen = 0; m_busy = 0; m_start = 0; m_txn = 0; m_ready = 0; m_last = 0; m_max = 0;
    m_active = 0; m_iter = 0; m_total = 0; m_run = 0; m_trip = 0; m_last_iter = 0;
  endtask

  task automatic hs_model();
    int lat;
    if (mon_if.ap_ready) m_ready++;
    if (m_busy) begin
      if (mon_if.ap_done && mon_if.ap_continue) begin
        lat    = cyc - m_start + 1;
        m_txn++;
        m_last = lat;
        if (lat > m_max) m_max = lat;
        if (mon_if.ap_start) m_start = cyc;
        else m_busy = 0;
      end
    end else if (mon_if.ap_start) begin
      m_busy  = 1;
      m_start = cyc;
    end
  endtask

  task automatic cycle();
    if (!reset) model_clear();
    else if (!m_frozen) begin
      hs_model();
      m_frozen = mon_if.finish;
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic set_hs(input logic s, input logic r, input logic d, input logic c);
    mon_if.ap_start = s; mon_if.ap_ready = r; mon_if.ap_done = d; mon_if.ap_continue = c;
  endtask

  task automatic set_idle();
    set_hs(0, 0, 0, 0);
    mon_if.finish          = 0;
    mon_if.one_state_loop  = 0;
    mon_if.one_state_block = 0;
    mon_if.cur_state       = onehot(0);
  endtask

  task automatic check_hs(input string tag);
    chk({tag, ".busy"},  mon_if.mod_busy,      m_busy);
    chk({tag, ".txn"},   mon_if.mod_txn_cnt,   m_txn);
    chk({tag, ".ready"}, mon_if.mod_ready_cnt, m_ready);
    chk({tag, ".last"},  mon_if.mod_last_lat,  m_last);
    chk({tag, ".max"},   mon_if.mod_max_lat,   m_max);
  endtask

  task automatic check_loop(input string tag);
    chk({tag, ".active"},   mon_if.loop_active,        m_active);
    chk({tag, ".iter"},     mon_if.loop_iter_cnt,      m_iter);
    chk({tag, ".total"},    mon_if.loop_total_iters,   m_total);
    chk({tag, ".runs"},     mon_if.loop_run_cnt,       m_run);
    chk({tag, ".trip"},     mon_if.loop_last_trip,     m_trip);
    chk({tag, ".iter_lat"}, mon_if.loop_last_iter_lat, m_last_iter);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".frozen"}, mon_if.frozen, m_frozen);
    check_hs(tag);
    check_loop(tag);
  endtask

  task automatic do_reset(input int n);
    reset = 0;
    model_clear();
    #1;
    check_all("rst_async");
    for (int i = 0; i < n; i++) begin
      set_hs(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      mon_if.finish          = 1'($urandom_range(0, 1));
      mon_if.one_state_loop  = 1'($urandom_range(0, 1));
      mon_if.one_state_block = 1'($urandom_range(0, 1));
      mon_if.cur_state       = onehot($urandom_range(0, STATE_W - 1));
      cycle();
    end
    check_all("rst_hold");
    set_idle();
    reset = 1;
  endtask

  // FSM walk: bit0, then n times [bit1, bits 2..L-1, bit301], then bit1, bit0.
  task automatic run_loop(input int n, input int body_len, input logic blocked, input string tag);
    mon_if.cur_state = onehot(0); cycle();
    mon_if.cur_state = onehot(1); cycle();
    if (!blocked) begin m_active = 1; m_iter = 0; end
    check_loop({tag, ".entry"});
    for (int it = 0; it < n; it++) begin
      for (int s = 2; s < body_len; s++) begin
        mon_if.cur_state = onehot(s); cycle();
      end
      mon_if.cur_state = onehot(STATE_W - 1); cycle();
      mon_if.cur_state = onehot(1); cycle();
      if (!blocked) begin m_iter++; m_total++; m_last_iter = body_len; end
      check_loop({tag, ".iter"});
    end
    mon_if.cur_state = onehot(0); cycle();
    if (!blocked) begin m_active = 0; m_run++; m_trip = n; end
    check_loop({tag, ".exit"});
  endtask

  initial begin
    reset = 0;
    model_clear();
    set_idle();
    mon_if.pre_loop_state0       = onehot(0);
    mon_if.post_loop_state0      = onehot(0);
    mon_if.quit_loop_state0      = onehot(1);
    mon_if.iter_start_state      = onehot(1);
    mon_if.iter_end_state0       = onehot(STATE_W - 1);
    mon_if.pre_states_valid      = 1;
    mon_if.post_states_valid     = 1;
    mon_if.quit_states_valid     = 1;
    mon_if.iter_end_states_valid = 1;

    do_reset(5);
    cycle();
    check_all("post_reset");

    // Ready-only
    set_hs(0, 1, 0, 0); repeat (3) cycle();
    set_hs(0, 0, 0, 0); cycle();
    chk("ready_only.ready", mon_if.mod_ready_cnt, 3);
    chk("ready_only.txn",   mon_if.mod_txn_cnt,   0);
    check_hs("ready_only");

    // Single transaction: start at cycle 0, done at cycle 9
    set_hs(1, 0, 0, 0); cycle();
    set_hs(0, 0, 0, 0); repeat (8) cycle();
    chk("single.busy_mid", mon_if.mod_busy, 1);
    set_hs(0, 0, 1, 1); cycle();
    set_hs(0, 0, 0, 0);
    chk("single.txn",  mon_if.mod_txn_cnt,  1);
    chk("single.last", mon_if.mod_last_lat, 10);
    chk("single.max",  mon_if.mod_max_lat,  10);
    chk("single.busy", mon_if.mod_busy,     0);
    check_hs("single");

    // Start and done in the same cycle restarts the latency count
    set_hs(1, 0, 0, 0); cycle();
    set_hs(0, 0, 0, 0); repeat (3) cycle();
    set_hs(1, 0, 1, 1); cycle();
    chk("b2b.last", mon_if.mod_last_lat, 5);
    chk("b2b.busy", mon_if.mod_busy,     1);
    set_hs(0, 0, 0, 0); cycle();
    set_hs(0, 0, 1, 1); cycle();
    chk("b2b.last2", mon_if.mod_last_lat, 3);
    chk("b2b.txn",   mon_if.mod_txn_cnt,  3);
    chk("b2b.max",   mon_if.mod_max_lat,  10);
    // Done while idle is ignored
    cycle();
    chk("idle_done.txn", mon_if.mod_txn_cnt, 3);
    check_hs("idle_done");

    // Random handshake traffic
    for (int i = 0; i < 300; i++) begin
      set_hs(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0),
             1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)));
      cycle();
      check_hs("rand_hs");
    end
    set_hs(0, 0, 0, 0);

    // Loop tracking disabled by one_state_block
    do_reset(3);
    mon_if.one_state_block = 1;
    run_loop(4, 301, 1'b1, "blocked");
    chk("blocked.total", mon_if.loop_total_iters, 0);
    chk("blocked.runs",  mon_if.loop_run_cnt,     0);
    mon_if.one_state_block = 0;

    // Spec loop run: body bit1..bit301, four iterations
    run_loop(4, 301, 1'b0, "loop301");
    chk("loop301.total",    mon_if.loop_total_iters,   4);
    chk("loop301.runs",     mon_if.loop_run_cnt,       1);
    chk("loop301.trip",     mon_if.loop_last_trip,     4);
    chk("loop301.iter_lat", mon_if.loop_last_iter_lat, 301);
    chk("loop301.active",   mon_if.loop_active,        0);

    // Random loop shapes
    for (int r = 0; r < 3; r++) begin
      run_loop($urandom_range(1, 5), $urandom_range(2, 40), 1'b0, "rand_loop");
    end

    // Single-state loop body: every cycle held in bit1 completes an iteration
    mon_if.one_state_loop = 1;
    mon_if.cur_state = onehot(0); cycle();
    mon_if.cur_state = onehot(1); cycle();
    m_active = 1; m_iter = 0;
    repeat (4) begin
      cycle();
      m_iter++; m_total++; m_last_iter = 1;
      check_loop("one_state");
    end
    mon_if.cur_state = onehot(0); cycle();
    m_active = 0; m_run++; m_trip = 4;
    check_loop("one_state.exit");
    mon_if.one_state_loop = 0;

    // Reset in the middle of a loop and a transaction
    set_hs(1, 0, 0, 0);
    mon_if.cur_state = onehot(0); cycle();
    set_hs(0, 0, 0, 0);
    mon_if.cur_state = onehot(1); cycle();
    mon_if.cur_state = onehot(2); cycle();
    chk("mid.active", mon_if.loop_active, 1);
    do_reset(2);
    cycle();
    check_all("mid.after_reset");

    // Freeze mid-transaction, completion afterwards is not recorded
    set_hs(1, 0, 0, 0); cycle();
    set_hs(0, 0, 0, 0); repeat (3) cycle();
    mon_if.finish = 1; cycle();
    mon_if.finish = 0;
    set_hs(0, 1, 1, 1); repeat (2) cycle();
    set_hs(1, 1, 0, 0); cycle();
    set_hs(0, 0, 0, 0);
    chk("freeze.frozen", mon_if.frozen,        1);
    chk("freeze.txn",    mon_if.mod_txn_cnt,   0);
    chk("freeze.busy",   mon_if.mod_busy,      1);
    chk("freeze.ready",  mon_if.mod_ready_cnt, 0);
    check_all("freeze");

    // Finish together with a completion: completion counts, then hold
    do_reset(2);
    set_hs(1, 0, 0, 0); cycle();
    set_hs(0, 0, 0, 0); repeat (4) cycle();
    set_hs(0, 0, 1, 1); mon_if.finish = 1; cycle();
    mon_if.finish = 0;
    set_hs(1, 1, 0, 0); repeat (3) cycle();
    set_hs(0, 0, 0, 0); cycle();
    chk("fin_done.frozen", mon_if.frozen,       1);
    chk("fin_done.txn",    mon_if.mod_txn_cnt,  1);
    chk("fin_done.last",   mon_if.mod_last_lat, 6);
    chk("fin_done.busy",   mon_if.mod_busy,     0);
    check_all("fin_done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
